// File: rtl/example_mac_dot_pipe_pkg.sv
// Shared types and the output saturation/wrap helper for the pipelined MAC.
package example_mac_pkg;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic valid;
    logic last;
  } beat_ctl_t;

  // Returns {ovf, value}; value is the clamped or wrapped result, sign-extended to MAX_W bits.
  function automatic logic [MAX_W:0] sat_trunc(input logic signed [MAX_W-1:0] acc,
                                               input int dout_width,
                                               input logic sat_en);
    logic signed [MAX_W-1:0] max_v;
    logic signed [MAX_W-1:0] min_v;
    logic signed [MAX_W-1:0] wrap_v;
    logic signed [MAX_W-1:0] res_v;
    logic ovf;
    max_v  = (64'sd1 <<< (dout_width - 1)) - 64'sd1;
    min_v  = -max_v - 64'sd1;
    wrap_v = (acc <<< (MAX_W - dout_width)) >>> (MAX_W - dout_width);
    res_v  = acc;
    ovf    = 1'b0;
    if (sat_en) begin
      if (acc > max_v) begin
        res_v = max_v;
        ovf   = 1'b1;
      end else if (acc < min_v) begin
        res_v = min_v;
        ovf   = 1'b1;
      end
    end else begin
      res_v = wrap_v;
      ovf   = (wrap_v != acc);
    end
    return {ovf, res_v};
  endfunction

endpackage

// File: rtl/example_mac_dot_pipe_mul.sv
// NUM_STAGE-deep full-precision signed multiplier with a shared clock enable.
module example_mul_pipe_DSP48 #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 14,
  parameter int NUM_STAGE = 3
) (
  input  logic                               clk,
  input  logic                               en,
  input  logic signed [A_WIDTH-1:0]          a,
  input  logic signed [B_WIDTH-1:0]          b,
  output logic signed [A_WIDTH+B_WIDTH-1:0]  p
);

  localparam int PW = A_WIDTH + B_WIDTH;

  logic signed [PW-1:0] p_q [NUM_STAGE];
  logic signed [PW-1:0] p_d [NUM_STAGE];

  always_comb begin
    p_d[0] = PW'(a) * PW'(b);
    for (int i = 1; i < NUM_STAGE; i++) begin
      p_d[i] = p_q[i-1];
    end
  end

  // Datapath only; validity is tracked by the control chain in the parent.
  always_ff @(posedge clk) begin
    if (en) begin
      p_q <= p_d;
    end
  end

  assign p = p_q[NUM_STAGE-1];

endmodule

// File: rtl/example_mac_dot_pipe.sv
// Pipelined signed dot-product unit: input register, multiplier pipe, accumulator and
// output register, all frozen together by a single stall enable.
module example_mac_dot_pipe
  import example_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 8,
  parameter int DIN1_WIDTH = 14,
  parameter int DOUT_WIDTH = 21,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_STAGE  = 3,
  parameter int LEN_WIDTH  = 8,
  parameter int SAT_EN     = 1
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DIN0_WIDTH-1:0]  din0,
  input  logic signed [DIN1_WIDTH-1:0]  din1,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DOUT_WIDTH-1:0]  dout,
  output logic                          dout_ovf,
  output logic [LEN_WIDTH-1:0]          dout_cnt
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  if (ACC_WIDTH < PROD_WIDTH || ACC_WIDTH > MAX_W) begin : g_acc_check
    $error("ACC_WIDTH must cover the full product and fit in 64 bits");
  end
  if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_stage_check
    $error("NUM_STAGE must be in 1..4");
  end
  if (DOUT_WIDTH < 2 || DOUT_WIDTH >= MAX_W) begin : g_dout_check
    $error("DOUT_WIDTH out of range");
  end

  logic en;
  logic signed [DIN0_WIDTH-1:0] a_q, a_d;
  logic signed [DIN1_WIDTH-1:0] b_q, b_d;
  beat_ctl_t in_ctl_q, in_ctl_d;
  beat_ctl_t ctl_q [NUM_STAGE];
  beat_ctl_t ctl_d [NUM_STAGE];
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] prod_ext, acc_q, acc_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, dout_cnt_q, dout_cnt_d;
  logic start_q, start_d, prod_valid, prod_last;
  logic out_valid_q, out_valid_d, dout_ovf_q, dout_ovf_d;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic signed [MAX_W-1:0] acc_wide;
  logic [MAX_W:0] sat_res;
  logic unused_sat_bits;

  assign en        = ~(out_valid_q & ~out_ready);
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign dout_ovf  = dout_ovf_q;
  assign dout_cnt  = dout_cnt_q;

  always_comb begin
    a_d      = en ? din0 : a_q;
    b_d      = en ? din1 : b_q;
    in_ctl_d = en ? '{valid: in_valid, last: in_last} : in_ctl_q;
    ctl_d[0] = en ? in_ctl_q : ctl_q[0];
    for (int i = 1; i < NUM_STAGE; i++) begin
      ctl_d[i] = en ? ctl_q[i-1] : ctl_q[i];
    end
  end

  example_mul_pipe_DSP48 #(
    .A_WIDTH   (DIN0_WIDTH),
    .B_WIDTH   (DIN1_WIDTH),
    .NUM_STAGE (NUM_STAGE)
  ) u_mul (
    .clk (ap_clk),
    .en  (en),
    .a   (a_q),
    .b   (b_q),
    .p   (prod)
  );

  // start_q marks that the next product opens a new vector (after a last beat or reset).
  always_comb begin
    prod_valid  = ctl_q[NUM_STAGE-1].valid & en;
    prod_last   = ctl_q[NUM_STAGE-1].last;
    prod_ext    = ACC_WIDTH'(prod);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    start_d     = start_q;
    if (prod_valid) begin
      acc_d   = start_q ? prod_ext : acc_q + prod_ext;
      cnt_d   = start_q ? LEN_WIDTH'(1) : ((&cnt_q) ? cnt_q : cnt_q + LEN_WIDTH'(1));
      start_d = prod_last;
    end
    acc_wide    = MAX_W'(acc_d);
    sat_res     = sat_trunc(acc_wide, DOUT_WIDTH, SAT_EN != 0);
    out_valid_d = out_valid_q & ~out_ready;
    dout_d      = dout_q;
    dout_ovf_d  = dout_ovf_q;
    dout_cnt_d  = dout_cnt_q;
    if (prod_valid && prod_last) begin
      out_valid_d = 1'b1;
      dout_d      = sat_res[DOUT_WIDTH-1:0];
      dout_ovf_d  = sat_res[MAX_W];
      dout_cnt_d  = cnt_d;
    end
  end

  assign unused_sat_bits = ^sat_res[MAX_W-1:DOUT_WIDTH];

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      in_ctl_q    <= '0;
      for (int i = 0; i < NUM_STAGE; i++) begin
        ctl_q[i] <= '0;
      end
      acc_q       <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      dout_ovf_q  <= 1'b0;
      dout_cnt_q  <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      in_ctl_q    <= in_ctl_d;
      ctl_q       <= ctl_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      dout_ovf_q  <= dout_ovf_d;
      dout_cnt_q  <= dout_cnt_d;
    end
  end

endmodule

// File: tb/tb_example_mac_dot_pipe.sv
// Directed bench for example_mac_dot_pipe: one saturating and one wrapping instance share stimulus.
module tb_example_mac_dot_pipe;

  localparam int NS = 3;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic signed [7:0] din0 = '0;
  logic signed [13:0] din1 = '0;

  logic in_ready_s, out_valid_s, dout_ovf_s;
  logic signed [20:0] dout_s;
  logic [7:0] dout_cnt_s;
  logic in_ready_w, out_valid_w, dout_ovf_w;
  logic signed [20:0] dout_w;
  logic [7:0] dout_cnt_w;

  int total = 0;
  int bad = 0;

  always #5 ap_clk = ~ap_clk;

  example_mac_dot_pipe #(.NUM_STAGE(NS), .SAT_EN(1)) dut_sat (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .din0(din0), .din1(din1), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .dout(dout_s), .dout_ovf(dout_ovf_s), .dout_cnt(dout_cnt_s)
  );

  example_mac_dot_pipe #(.NUM_STAGE(NS), .SAT_EN(0)) dut_wrap (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .din0(din0), .din1(din1), .in_last(in_last), .out_valid(out_valid_w),
    .out_ready(out_ready), .dout(dout_w), .dout_ovf(dout_ovf_w), .dout_cnt(dout_cnt_w)
  );

  // Holds one beat on the inputs until it is accepted at a rising edge.
  task automatic send_beat(input int a, input int b, input logic last);
    int guard = 0;
    din0 = 8'(a);
    din1 = 14'(b);
    in_last = last;
    in_valid = 1'b1;
    while (!in_ready_s && guard < 50) begin
      @(posedge ap_clk); #1;
      guard++;
    end
    total++;
    if (guard >= 50) begin
      bad++;
      $display("[TB] FAIL send_timeout: in_ready got %b want 1", in_ready_s);
    end
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    total++; if (out_valid_s !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid_s); end
    total++; if (int'(dout_s) !== 0) begin bad++; $display("[TB] FAIL reset_dout: got %0d want 0", dout_s); end
    total++; if (dout_ovf_s !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", dout_ovf_s); end
    total++; if (int'(dout_cnt_s) !== 0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d want 0", dout_cnt_s); end
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    total++; if (in_ready_s !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready_s); end
  endtask

  task automatic test_vector_latency();
    int cyc = 0;
    out_ready = 1'b1;
    send_beat(3, 100, 1'b0);
    @(posedge ap_clk); #1;
    send_beat(-2, 50, 1'b0);
    send_beat(127, 8191, 1'b1);
    while (!out_valid_s && cyc < 20) begin
      @(posedge ap_clk); #1;
      cyc++;
    end
    total++; if (cyc !== NS + 1) begin bad++; $display("[TB] FAIL vec_latency: got %0d want %0d", cyc, NS + 1); end
    total++; if (int'(dout_s) !== 1040457) begin bad++; $display("[TB] FAIL vec_dout: got %0d want 1040457", dout_s); end
    total++; if (dout_ovf_s !== 1'b0) begin bad++; $display("[TB] FAIL vec_ovf: got %b want 0", dout_ovf_s); end
    total++; if (int'(dout_cnt_s) !== 3) begin bad++; $display("[TB] FAIL vec_cnt: got %0d want 3", dout_cnt_s); end
    total++; if (int'(dout_w) !== 1040457) begin bad++; $display("[TB] FAIL vec_dout_wrap: got %0d want 1040457", dout_w); end
    @(posedge ap_clk); #1;
    total++; if (out_valid_s !== 1'b0) begin bad++; $display("[TB] FAIL vec_consumed: got %b want 0", out_valid_s); end
  endtask

  task automatic test_saturate();
    int cyc = 0;
    send_beat(-128, -8192, 1'b1);
    while (!out_valid_s && cyc < 20) begin @(posedge ap_clk); #1; cyc++; end
    total++; if (out_valid_s !== 1'b1) begin bad++; $display("[TB] FAIL sat_timeout: got %b want 1", out_valid_s); end
    total++; if (int'(dout_s) !== 1048575) begin bad++; $display("[TB] FAIL sat_dout: got %0d want 1048575", dout_s); end
    total++; if (dout_ovf_s !== 1'b1) begin bad++; $display("[TB] FAIL sat_ovf: got %b want 1", dout_ovf_s); end
    total++; if (int'(dout_cnt_s) !== 1) begin bad++; $display("[TB] FAIL sat_cnt: got %0d want 1", dout_cnt_s); end
    total++; if (int'(dout_w) !== -1048576) begin bad++; $display("[TB] FAIL sat_dout_wrap: got %0d want -1048576", dout_w); end
    total++; if (dout_ovf_w !== 1'b1) begin bad++; $display("[TB] FAIL sat_ovf_wrap: got %b want 1", dout_ovf_w); end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_wrap();
    int cyc = 0;
    send_beat(127, 8191, 1'b0);
    send_beat(127, 8191, 1'b1);
    while (!out_valid_w && cyc < 20) begin @(posedge ap_clk); #1; cyc++; end
    total++; if (out_valid_w !== 1'b1) begin bad++; $display("[TB] FAIL wrap_timeout: got %b want 1", out_valid_w); end
    total++; if (int'(dout_w) !== -16638) begin bad++; $display("[TB] FAIL wrap_dout: got %0d want -16638", dout_w); end
    total++; if (dout_ovf_w !== 1'b1) begin bad++; $display("[TB] FAIL wrap_ovf: got %b want 1", dout_ovf_w); end
    total++; if (int'(dout_cnt_w) !== 2) begin bad++; $display("[TB] FAIL wrap_cnt: got %0d want 2", dout_cnt_w); end
    total++; if (int'(dout_s) !== 1048575) begin bad++; $display("[TB] FAIL wrap_dout_sat: got %0d want 1048575", dout_s); end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int exp_v [3] = '{1, 4, 9};
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      total++; if (in_ready_s !== 1'b1) begin bad++; $display("[TB] FAIL b2b_in_ready: got %b want 1", in_ready_s); end
      send_beat(i, i, 1'b1);
    end
    while (!out_valid_s && cyc < 20) begin @(posedge ap_clk); #1; cyc++; end
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid_s !== 1'b1) begin bad++; $display("[TB] FAIL b2b_valid: got %b want 1", out_valid_s); end
      total++; if (int'(dout_s) !== exp_v[i]) begin bad++; $display("[TB] FAIL b2b_dout: got %0d want %0d", dout_s, exp_v[i]); end
      total++; if (in_ready_s !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready_drain: got %b want 1", in_ready_s); end
      @(posedge ap_clk); #1;
    end
    total++; if (out_valid_s !== 1'b0) begin bad++; $display("[TB] FAIL b2b_end: got %b want 0", out_valid_s); end
  endtask

  task automatic test_stall();
    int cyc = 0;
    out_ready = 1'b0;
    send_beat(2, 3, 1'b1);
    send_beat(4, 5, 1'b1);
    send_beat(-6, 7, 1'b1);
    while (!out_valid_s && cyc < 20) begin @(posedge ap_clk); #1; cyc++; end
    for (int i = 0; i < 5; i++) begin
      total++; if (in_ready_s !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready: got %b want 0", in_ready_s); end
      total++; if (out_valid_s !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid: got %b want 1", out_valid_s); end
      total++; if (int'(dout_s) !== 6) begin bad++; $display("[TB] FAIL stall_dout: got %0d want 6", dout_s); end
      @(posedge ap_clk); #1;
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    total++; if (int'(dout_s) !== 20 || out_valid_s !== 1'b1) begin bad++; $display("[TB] FAIL stall_drain2: got %0d/%b want 20/1", dout_s, out_valid_s); end
    @(posedge ap_clk); #1;
    total++; if (int'(dout_s) !== -42 || out_valid_s !== 1'b1) begin bad++; $display("[TB] FAIL stall_drain3: got %0d/%b want -42/1", dout_s, out_valid_s); end
    total++; if (int'(dout_cnt_s) !== 1) begin bad++; $display("[TB] FAIL stall_cnt: got %0d want 1", dout_cnt_s); end
    @(posedge ap_clk); #1;
    total++; if (out_valid_s !== 1'b0) begin bad++; $display("[TB] FAIL stall_end: got %b want 0", out_valid_s); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    out_ready = 1'b1;
    send_beat(9, 9, 1'b0);
    send_beat(10, 10, 1'b0);
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    total++; if (out_valid_s !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid: got %b want 0", out_valid_s); end
    total++; if (int'(dout_s) !== 0) begin bad++; $display("[TB] FAIL mid_dout: got %0d want 0", dout_s); end
    total++; if (int'(dout_cnt_s) !== 0 || dout_ovf_s !== 1'b0) begin bad++; $display("[TB] FAIL mid_cnt_ovf: got %0d/%b want 0/0", dout_cnt_s, dout_ovf_s); end
    ap_rst_n = 1'b1;
    send_beat(5, 5, 1'b1);
    while (!out_valid_s && cyc < 20) begin @(posedge ap_clk); #1; cyc++; end
    total++; if (int'(dout_s) !== 25) begin bad++; $display("[TB] FAIL mid_dout_after: got %0d want 25", dout_s); end
    total++; if (int'(dout_cnt_s) !== 1) begin bad++; $display("[TB] FAIL mid_cnt_after: got %0d want 1", dout_cnt_s); end
    total++; if (cyc !== NS + 1) begin bad++; $display("[TB] FAIL mid_latency: got %0d want %0d", cyc, NS + 1); end
    @(posedge ap_clk); #1;
  endtask

  initial begin
    test_reset();
    test_vector_latency();
    test_saturate();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
